pic_ack_controller: RTL and testbench
=====================================

Name: pic_ack_controller

Overview:
- Sequences the interrupt acknowledge cycle of the 8259A-compatible PIC.
- Samples pending requests against the mask and the in-service state, then raises INT.
- Runs the two-pulse INTA protocol: the first pulse freezes the winning level, sets its ISR bit and clears its IRR bit; the second pulse drives the vector.
- Owns ISR, the rotating-priority pointer and all OCW2 EOI/rotation commands. It sits between the IRR/IMR register file and the data-bus buffer.

Parameters:
- NUM_IRQ, 8, number of request lines. Fixed at 8 for 8259A compatibility; level index width is 3.
- SYNC_STAGES, 2, synchroniser depth for the asynchronous INTA input.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- IRR  in  8  latched interrupt requests
- IMR  in  8  interrupt mask, 1 = masked
- ICW2  in  5  vector base T7..T3
- AEOI  in  1  auto-EOI mode, from ICW4
- OCW2  in  8  operation command word 2
- OCW2_WR  in  1  one-cycle strobe: OCW2 is valid
- INTA  in  1  interrupt acknowledge, active low, asynchronous
- INT  out  1  interrupt request to CPU
- ISR  out  8  in-service register
- IRR_CLR  out  8  one-cycle one-hot pulse clearing the acknowledged IRR bit
- VECTOR  out  8  vector byte
- VECTOR_OE  out  1  VECTOR valid / drive data bus
- BUSY  out  1  acknowledge sequence in progress

Behaviour:
- Reset values: ISR=0, INT=0, IRR_CLR=0, VECTOR=0, VECTOR_OE=0, BUSY=0, lowest-priority pointer LP=7 (IR0 highest), rotate-in-AEOI flag=0, FSM=IDLE, synchroniser flops=1.
- Priority: highest level = (LP+1) mod 8, descending cyclically.
- Pending set: P = IRR & ~IMR.
- Fully nested rule: INT=1 (registered, 1-cycle latency) iff some P bit has strictly higher priority than the highest-priority ISR bit; any P bit qualifies if ISR=0.
- INTA edges are detected on the synchronised signal, so latency is SYNC_STAGES+1 cycles from the pin.
- FSM states:
  - IDLE: a falling INTA edge goes to ACK1.
  - ACK1: one cycle. Winner W = highest-priority qualifying P bit. ISR[W] set, IRR_CLR[W] pulsed, INT deasserted, BUSY=1, go to WAIT_R1.
    - Spurious case: no qualifying bit at ACK1. W=7, ISR unchanged, IRR_CLR=0.
  - WAIT_R1: a rising edge goes to WAIT_F2.
  - WAIT_F2: a falling edge goes to ACK2.
  - ACK2: VECTOR={ICW2,W}, VECTOR_OE=1 held until the rising edge, then go to DONE.
  - DONE: one cycle. VECTOR_OE=0, BUSY=0.
    - If AEOI=1 and not spurious: ISR[W] cleared.
    - If the rotate-in-AEOI flag is also set: LP=W.
    - Go to IDLE.
- OCW2 is decoded on OCW2_WR by bits [7:5]:
  - 001: non-specific EOI, clears the highest-priority ISR bit.
  - 011: specific EOI, clears ISR[OCW2[2:0]].
  - 101: rotate on non-specific EOI, clears that bit and sets LP to it.
  - 111: rotate on specific EOI, clears ISR[L] and sets LP=L.
  - 110: set priority, LP=OCW2[2:0].
  - 100 / 000: set / clear the rotate-in-AEOI flag.
  - 010: no-op.
  - EOI with ISR=0: no change.
- Simultaneous events:
  - OCW2 EOI in the same cycle as ACK1: the EOI is evaluated on the pre-set ISR, and both updates apply.
  - Same bit cleared and set in one cycle: set wins.
- INTA edges arriving in DONE are ignored.
- A reset mid-sequence aborts immediately to reset values.

Optional Feature:
- PIC_AUTO_EOI_EN
  - Defined: the AEOI input and the 100/000 rotate-in-AEOI commands behave as above.
  - Undefined: AEOI is ignored (treated as 0), 100/000 are no-ops, the rotate flag is tied 0, and ISR clears only via OCW2 EOI.

Decomposition:
- Package pic_pkg holds:
  - FSM state enum (IDLE, ACK1, WAIT_R1, WAIT_F2, ACK2, DONE)
  - OCW2 command encodings
  - SPURIOUS_LEVEL=3'd7 and RESET_LP=3'd7
- Sub-module pic_priority_select: combinational.
  - Inputs: an 8-bit vector and LP.
  - Outputs: a found flag and the 3-bit index of the highest-priority set bit, with rotation applied.
  - Instantiated twice: once for qualifying P, once for ISR (non-specific EOI and nesting compare).

Test Plan:
- Fixed priority, IRR=0x24, IMR=0 -> INT=1. INTA pulse 1 -> ISR=0x04, IRR_CLR=0x04. Pulse 2 with ICW2=5'h08 -> VECTOR=0x42, VECTOR_OE=1. OCW2=0x20 -> ISR=0x00.
- Nesting: ISR=0x04 with IRR=0x08 -> INT=0. IRR=0x01 -> INT=1. Acknowledge -> ISR=0x05.
- Rotation: OCW2=0xC3 (LP=3), IRR=0x11 -> IR4 acknowledged, VECTOR low bits=4. OCW2=0xA0 -> ISR=0, LP=4.
- Spurious: IRR=0x02, INT=1, IRR drops before INTA -> VECTOR={ICW2,3'd7}, ISR unchanged.
- AEOI=1 with rotate flag set (OCW2=0x80), IRR=0x40 -> ISR=0 after DONE, LP=6. Macro-undefined build -> ISR=0x40 retained.
- Reset asserted in WAIT_F2 -> all outputs 0 and LP=7 asynchronously. After release, a single INTA pair works normally.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A-compatible interrupt acknowledge controller.
// Optional auto-EOI support is selected by the PIC_AUTO_EOI_EN macro in pic_ack_controller.
package pic_pkg;

   localparam int LVL_W = 3;

   localparam logic [LVL_W-1:0] SPURIOUS_LEVEL = 3'd7;
   localparam logic [LVL_W-1:0] RESET_LP       = 3'd7;

   typedef enum logic [2:0] {
      IDLE,
      ACK1,
      WAIT_R1,
      WAIT_F2,
      ACK2,
      DONE
   } ack_state_e;

   typedef enum logic [2:0] {
      OCW2_CLR_ROT_AEOI = 3'b000,
      OCW2_NS_EOI       = 3'b001,
      OCW2_NOP          = 3'b010,
      OCW2_SP_EOI       = 3'b011,
      OCW2_SET_ROT_AEOI = 3'b100,
      OCW2_ROT_NS_EOI   = 3'b101,
      OCW2_SET_PRIO     = 3'b110,
      OCW2_ROT_SP_EOI   = 3'b111
   } ocw2_cmd_e;

   // Position of a level in the rotated order: 0 is the highest priority.
   function automatic logic [LVL_W-1:0] prio_rank(input logic [LVL_W-1:0] lvl,
                                                  input logic [LVL_W-1:0] lp);
      return lvl - lp - 3'd1;
   endfunction

endpackage

// File: rtl/pic_priority_select.sv
// Rotating-priority encoder: finds the highest-priority set bit when level LP is lowest
// priority and (LP+1) mod 8 is highest.
module pic_priority_select
   import pic_pkg::*;
(
   input  logic [7:0]       vec,
   input  logic [LVL_W-1:0] lp,
   output logic             found,
   output logic [LVL_W-1:0] idx
);

   logic [15:0]      dbl;
   logic [7:0]       rot;
   logic [LVL_W-1:0] first;

   // NOTE: every variable written here gets a default first, so no latch can be inferred.
   always_comb begin
      dbl   = {vec, vec};
      rot   = 8'(dbl >> (4'(lp) + 4'd1));
      found = |rot;
      first = '0;
      for (int k = 7; k >= 0; k--) begin
         if (rot[k]) first = 3'(k);
      end
      idx = first + lp + 3'd1;
   end

endmodule

// File: rtl/pic_ack_controller.sv
// 8259A-style interrupt acknowledge sequencer: owns ISR, the priority pointer and OCW2 commands.
// Define PIC_AUTO_EOI_EN to enable the AEOI input and the rotate-in-AEOI commands.
module pic_ack_controller
   import pic_pkg::*;
#(
   parameter int NUM_IRQ     = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] IRR,
   input  logic [NUM_IRQ-1:0] IMR,
   input  logic [4:0]         ICW2,
   input  logic               AEOI,
   input  logic [7:0]         OCW2,
   input  logic               OCW2_WR,
   input  logic               INTA,
   output logic               INT,
   output logic [NUM_IRQ-1:0] ISR,
   output logic [NUM_IRQ-1:0] IRR_CLR,
   output logic [7:0]         VECTOR,
   output logic               VECTOR_OE,
   output logic               BUSY
);

   ack_state_e state_q, state_d;

   logic [SYNC_STAGES-1:0] inta_sync;
   logic                   inta_prev;
   logic                   inta_fall, inta_rise;

   logic [NUM_IRQ-1:0] pend;
   logic               pend_found, isr_found;
   logic [LVL_W-1:0]   pend_idx, isr_idx;
   logic               qualify;

   logic [LVL_W-1:0]   lp_q, lp_d;
   logic [LVL_W-1:0]   win_q;
   logic               spur_q;
   logic               rot_q, rot_d;
   logic               aeoi_en;
   logic [NUM_IRQ-1:0] isr_set, isr_clr, isr_d;
   logic [LVL_W-1:0]   ocw2_lvl;

   // INTA is asynchronous; the flops idle high so reset never fakes a falling edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inta_sync <= '1;
         inta_prev <= 1'b1;
      end else begin
         // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
         inta_sync <= {inta_sync[SYNC_STAGES-2:0], INTA};
         inta_prev <= inta_sync[SYNC_STAGES-1];
      end
   end

   assign inta_fall = inta_prev & ~inta_sync[SYNC_STAGES-1];
   assign inta_rise = ~inta_prev & inta_sync[SYNC_STAGES-1];

   assign pend = IRR & ~IMR;

   pic_priority_select u_pend_sel (
      .vec   (pend),
      .lp    (lp_q),
      .found (pend_found),
      .idx   (pend_idx)
   );

   pic_priority_select u_isr_sel (
      .vec   (ISR),
      .lp    (lp_q),
      .found (isr_found),
      .idx   (isr_idx)
   );

   // Fully nested: a request wins only if it outranks everything already in service.
   assign qualify = pend_found &&
                    (!isr_found || (prio_rank(pend_idx, lp_q) < prio_rank(isr_idx, lp_q)));

   always_comb begin
      state_d   = state_q;
      IRR_CLR   = '0;
      VECTOR    = '0;
      VECTOR_OE = 1'b0;
      BUSY      = 1'b0;
      case (state_q)
         IDLE: begin
            if (inta_fall) state_d = ACK1;
         end
         ACK1: begin
            BUSY    = 1'b1;
            if (qualify) IRR_CLR = {{(NUM_IRQ-1){1'b0}}, 1'b1} << pend_idx;
            state_d = WAIT_R1;
         end
         WAIT_R1: begin
            BUSY = 1'b1;
            if (inta_rise) state_d = WAIT_F2;
         end
         WAIT_F2: begin
            BUSY = 1'b1;
            if (inta_fall) state_d = ACK2;
         end
         ACK2: begin
            BUSY      = 1'b1;
            VECTOR    = {ICW2, win_q};
            VECTOR_OE = 1'b1;
            if (inta_rise) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign ocw2_lvl = OCW2[2:0];

   // Clears are gathered first and the ACK1 set is OR-ed in last, so a set always wins.
   // An OCW2 pointer update overrides an auto-EOI rotation landing in the same cycle.
   always_comb begin
      isr_set = '0;
      isr_clr = '0;
      lp_d    = lp_q;
      rot_d   = rot_q;
      if (state_q == ACK1 && qualify) isr_set[pend_idx] = 1'b1;
      if (state_q == DONE && aeoi_en && !spur_q) begin
         isr_clr[win_q] = 1'b1;
         if (rot_q) lp_d = win_q;
      end
      if (OCW2_WR) begin
         case (ocw2_cmd_e'(OCW2[7:5]))
            OCW2_NS_EOI: begin
               if (isr_found) isr_clr[isr_idx] = 1'b1;
            end
            OCW2_SP_EOI: isr_clr[ocw2_lvl] = 1'b1;
            OCW2_ROT_NS_EOI: begin
               if (isr_found) begin
                  isr_clr[isr_idx] = 1'b1;
                  lp_d             = isr_idx;
               end
            end
            OCW2_ROT_SP_EOI: begin
               if (|ISR) begin
                  isr_clr[ocw2_lvl] = 1'b1;
                  lp_d              = ocw2_lvl;
               end
            end
            OCW2_SET_PRIO:     lp_d  = ocw2_lvl;
            OCW2_SET_ROT_AEOI: rot_d = 1'b1;
            OCW2_CLR_ROT_AEOI: rot_d = 1'b0;
            default: ;
         endcase
      end
      isr_d = (ISR & ~isr_clr) | isr_set;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ISR     <= '0;
         lp_q    <= RESET_LP;
         INT     <= 1'b0;
         win_q   <= SPURIOUS_LEVEL;
         spur_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ISR     <= isr_d;
         lp_q    <= lp_d;
         INT     <= (state_q == IDLE) && qualify;
         if (state_q == ACK1) begin
            win_q  <= qualify ? pend_idx : SPURIOUS_LEVEL;
            spur_q <= !qualify;
         end
      end
   end

`ifdef PIC_AUTO_EOI_EN
   assign aeoi_en = AEOI;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rot_q <= 1'b0;
      else       rot_q <= rot_d;
   end
`else
   assign aeoi_en = 1'b0;
   assign rot_q   = 1'b0;

   logic unused_auto_eoi;
   assign unused_auto_eoi = AEOI ^ rot_d;
`endif

   logic unused_ocw2;
   assign unused_ocw2 = ^OCW2[4:3];

endmodule

// File: tb/tb_pic_ack_controller.sv
// Self-checking bench for pic_ack_controller: directed acknowledge scenarios plus random traffic
// compared every cycle against a rank-based behavioural model.
module tb_pic_ack_controller;

   localparam int SS = 2;
   localparam int PH_IDLE = 0, PH_ACK1 = 1, PH_WAIT_R1 = 2, PH_WAIT_F2 = 3, PH_ACK2 = 4, PH_DONE = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] irr_q, IRR, IMR, OCW2, ISR, IRR_CLR, VECTOR;
   logic [4:0] ICW2;
   logic       AEOI, OCW2_WR, INTA, INT, VECTOR_OE, BUSY;

   int         n_vec = 0;
   int         n_err = 0;
   bit         cmp_en = 1'b0;
   logic [7:0] last_clr;

   assign IRR = irr_q;

   pic_ack_controller #(.NUM_IRQ(8), .SYNC_STAGES(SS)) dut (
      .clk       (clk),
      .reset     (reset),
      .IRR       (IRR),
      .IMR       (IMR),
      .ICW2      (ICW2),
      .AEOI      (AEOI),
      .OCW2      (OCW2),
      .OCW2_WR   (OCW2_WR),
      .INTA      (INTA),
      .INT       (INT),
      .ISR       (ISR),
      .IRR_CLR   (IRR_CLR),
      .VECTOR    (VECTOR),
      .VECTOR_OE (VECTOR_OE),
      .BUSY      (BUSY)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [7:0] isr;
      int         lp;
      bit         rot;
      bit         intr;
      int         phase;
      int         w;
      bit         spur;
      bit [SS:0]  hist;   // INTA pin samples, [0] newest
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r.isr = 8'h00; r.lp = 7; r.rot = 1'b0; r.intr = 1'b0;
      r.phase = PH_IDLE; r.w = 7; r.spur = 1'b0; r.hist = '1;
      return r;
   endfunction

   // Rank (0 = highest) of the highest-priority set bit, 8 when none is set.
   function automatic int top_rank(input logic [7:0] v, input int lp);
      for (int r = 0; r < 8; r++) begin
         if (v[(lp + 1 + r) % 8]) return r;
      end
      return 8;
   endfunction

   function automatic model_t model_step(input model_t c);
      model_t n    = c;
      int     pr   = top_rank(IRR & ~IMR, c.lp);
      int     ir   = top_rank(c.isr, c.lp);
      bit     q    = pr < ir;
      bit     fall = !c.hist[SS-1] && c.hist[SS];
      bit     rise = c.hist[SS-1] && !c.hist[SS];
      int     lvl  = int'(OCW2[2:0]);
      int     itop = (c.lp + 1 + ir) % 8;
`ifdef PIC_AUTO_EOI_EN
      bit     aeoi = AEOI;
`else
      bit     aeoi = 1'b0;
`endif
      if (c.phase == PH_DONE && aeoi && !c.spur) begin
         n.isr[c.w] = 1'b0;
         if (c.rot) n.lp = c.w;
      end
      if (OCW2_WR) begin
         case (OCW2[7:5])
            3'b001: if (ir < 8) n.isr[itop] = 1'b0;
            3'b011: n.isr[lvl] = 1'b0;
            3'b101: if (ir < 8) begin n.isr[itop] = 1'b0; n.lp = itop; end
            3'b111: if (c.isr != 0) begin n.isr[lvl] = 1'b0; n.lp = lvl; end
            3'b110: n.lp = lvl;
`ifdef PIC_AUTO_EOI_EN
            3'b100: n.rot = 1'b1;
            3'b000: n.rot = 1'b0;
`endif
            default: ;
         endcase
      end
      if (c.phase == PH_ACK1) begin
         n.w    = q ? (c.lp + 1 + pr) % 8 : 7;
         n.spur = !q;
         if (q) n.isr[n.w] = 1'b1;
      end
      n.intr = (c.phase == PH_IDLE) && q;
      case (c.phase)
         PH_IDLE:    if (fall) n.phase = PH_ACK1;
         PH_ACK1:    n.phase = PH_WAIT_R1;
         PH_WAIT_R1: if (rise) n.phase = PH_WAIT_F2;
         PH_WAIT_F2: if (fall) n.phase = PH_ACK2;
         PH_ACK2:    if (rise) n.phase = PH_DONE;
         default:    n.phase = PH_IDLE;
      endcase
      n.hist = {c.hist[SS-1:0], INTA};
      return n;
   endfunction

   function automatic logic [7:0] exp_clr(input model_t c);
      int pr = top_rank(IRR & ~IMR, c.lp);
      int ir = top_rank(c.isr, c.lp);
      if (c.phase == PH_ACK1 && pr < ir) return 8'(1) << ((c.lp + 1 + pr) % 8);
      return 8'h00;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) m <= model_reset();
      else       m <= model_step(m);
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("cyc_INT", {7'd0, INT}, {7'd0, m.intr});
         check("cyc_ISR", ISR, m.isr);
         check("cyc_IRR_CLR", IRR_CLR, exp_clr(m));
         check("cyc_BUSY", {7'd0, BUSY}, {7'd0, (m.phase >= PH_ACK1 && m.phase <= PH_ACK2)});
         check("cyc_VECTOR_OE", {7'd0, VECTOR_OE}, {7'd0, (m.phase == PH_ACK2)});
         check("cyc_VECTOR", VECTOR, (m.phase == PH_ACK2) ? {ICW2, 3'(m.w)} : 8'h00);
      end
   end

   // ---------------- stimulus helpers ----------------
   // The bench plays the IRR register file: acknowledged bits drop after the ACK1 cycle.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         last_clr = IRR_CLR;
         @(posedge clk);
         #1;
         irr_q = irr_q & ~last_clr;
      end
   endtask

   task automatic inta_low();
      INTA = 1'b0;
      tick(4);
   endtask

   task automatic inta_high();
      INTA = 1'b1;
      tick(4);
   endtask

   task automatic ack_cycle(output logic [7:0] vec, output logic [7:0] clr1);
      inta_low();
      clr1 = last_clr;
      inta_high();
      inta_low();
      vec = VECTOR;
      inta_high();
   endtask

   task automatic ocw2(input logic [7:0] v);
      OCW2    = v;
      OCW2_WR = 1'b1;
      tick(1);
      OCW2_WR = 1'b0;
      tick(1);
   endtask

   logic [7:0] vec, clr1;
   int         hold;

   initial begin
      INTA = 1'b1; irr_q = 8'h00; IMR = 8'h00; ICW2 = 5'h00; AEOI = 1'b0;
      OCW2 = 8'h00; OCW2_WR = 1'b0; last_clr = 8'h00;
      #1 reset = 1'b1;
      #1 cmp_en = 1'b1;
      check("rst_INT", {7'd0, INT}, 8'h00);
      check("rst_ISR", ISR, 8'h00);
      check("rst_VECTOR", VECTOR, 8'h00);
      check("rst_BUSY", {7'd0, BUSY}, 8'h00);
      tick(3);
      reset = 1'b0;
      tick(3);

      // Fixed priority, two-pulse acknowledge of IR2.
      ICW2  = 5'h08;
      irr_q = 8'h24;
      tick(1);
      check("t1_INT", {7'd0, INT}, 8'h01);
      inta_low();
      check("t1_ISR", ISR, 8'h04);
      check("t1_IRR_CLR", last_clr, 8'h04);
      check("t1_BUSY", {7'd0, BUSY}, 8'h01);
      check("t1_INT_drop", {7'd0, INT}, 8'h00);
      inta_high();
      inta_low();
      check("t1_VECTOR", VECTOR, 8'h42);
      check("t1_VECTOR_OE", {7'd0, VECTOR_OE}, 8'h01);
      inta_high();
      check("t1_BUSY_end", {7'd0, BUSY}, 8'h00);
      check("t1_ISR_kept", ISR, 8'h04);
      ocw2(8'h20);
      check("t1_EOI", ISR, 8'h00);
      irr_q = 8'h00;
      tick(2);

      // Fully nested: lower request blocked, higher one nests.
      irr_q = 8'h04;
      tick(1);
      ack_cycle(vec, clr1);
      irr_q = 8'h08;
      tick(2);
      check("t2_INT_blocked", {7'd0, INT}, 8'h00);
      irr_q = 8'h09;
      tick(2);
      check("t2_INT_nest", {7'd0, INT}, 8'h01);
      ack_cycle(vec, clr1);
      check("t2_VECTOR", vec, 8'h40);
      check("t2_ISR", ISR, 8'h05);
      irr_q = 8'h00;
      ocw2(8'h20);
      ocw2(8'h20);
      check("t2_ISR_clear", ISR, 8'h00);

      // Rotation: LP=3 makes IR4 highest; rotate-on-EOI moves LP to 4.
      ocw2(8'hC3);
      irr_q = 8'h11;
      tick(2);
      ack_cycle(vec, clr1);
      check("t3_VECTOR", vec, 8'h44);
      check("t3_ISR", ISR, 8'h10);
      ocw2(8'hA0);
      check("t3_ISR_rot", ISR, 8'h00);
      irr_q = irr_q | 8'h20;
      tick(2);
      ack_cycle(vec, clr1);
      check("t3_LP4_VECTOR", vec, 8'h45);
      irr_q = 8'h00;
      ocw2(8'h20);
      ocw2(8'hC7);
      tick(2);

      // Spurious: request withdrawn before INTA.
      irr_q = 8'h02;
      tick(2);
      check("t4_INT", {7'd0, INT}, 8'h01);
      irr_q = 8'h00;
      ack_cycle(vec, clr1);
      check("t4_VECTOR", vec, 8'h47);
      check("t4_IRR_CLR", clr1, 8'h00);
      check("t4_ISR", ISR, 8'h00);

      // Auto-EOI with rotate flag.
      AEOI = 1'b1;
      ocw2(8'h80);
      irr_q = 8'h40;
      tick(2);
      ack_cycle(vec, clr1);
      check("t5_VECTOR", vec, 8'h46);
      irr_q = 8'h81;
      tick(2);
`ifdef PIC_AUTO_EOI_EN
      check("t5_ISR_aeoi", ISR, 8'h00);
      ack_cycle(vec, clr1);
      check("t5_LP6_VECTOR", vec, 8'h47);
      check("t5_LP6_CLR", clr1, 8'h80);
      check("t5_ISR_aeoi2", ISR, 8'h00);
`else
      check("t5_ISR_kept", ISR, 8'h40);
      ack_cycle(vec, clr1);
      check("t5_LP7_VECTOR", vec, 8'h40);
      check("t5_LP7_CLR", clr1, 8'h01);
      check("t5_ISR_nest", ISR, 8'h41);
`endif
      AEOI  = 1'b0;
      irr_q = 8'h00;
      ocw2(8'h00);
      ocw2(8'h20);
      ocw2(8'h20);
      ocw2(8'hC7);

      // Reset in WAIT_F2, with LP moved away from its reset value beforehand.
      ocw2(8'hC2);
      irr_q = 8'h08;
      tick(2);
      inta_low();
      check("t6_ISR_pre", ISR, 8'h08);
      inta_high();
      check("t6_BUSY_pre", {7'd0, BUSY}, 8'h01);
      INTA = 1'b0;
      tick(1);
      #2 reset = 1'b1;
      #1;
      check("t6_rst_ISR", ISR, 8'h00);
      check("t6_rst_BUSY", {7'd0, BUSY}, 8'h00);
      check("t6_rst_INT", {7'd0, INT}, 8'h00);
      check("t6_rst_OE", {7'd0, VECTOR_OE}, 8'h00);
      check("t6_rst_CLR", IRR_CLR, 8'h00);
      check("t6_rst_VECTOR", VECTOR, 8'h00);
      irr_q = 8'h00;
      INTA  = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(3);
      irr_q = 8'h81;
      tick(2);
      ack_cycle(vec, clr1);
      check("t6_after_VECTOR", vec, 8'h40);
      check("t6_after_ISR", ISR, 8'h01);
      irr_q = 8'h00;
      ocw2(8'h20);

      // Random traffic checked cycle by cycle against the model.
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 3) == 0) irr_q = irr_q | (8'($urandom) & 8'($urandom));
         if ($urandom_range(0, 15) == 0) IMR = 8'($urandom) & 8'($urandom) & 8'($urandom);
         if ($urandom_range(0, 31) == 0) ICW2 = 5'($urandom);
         if ($urandom_range(0, 15) == 0) AEOI = 1'($urandom);
         if ($urandom_range(0, 5) == 0) begin
            OCW2    = 8'($urandom);
            OCW2_WR = 1'b1;
         end
         INTA = 1'($urandom);
         hold = $urandom_range(1, 6);
         tick(1);
         OCW2_WR = 1'b0;
         tick(hold - 1);
      end

      INTA = 1'b1;
      tick(8);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
